// File: rtl/tick_gen_pkg.sv
// Shared timebase constants and types for the microwave controller tick generators.
package tick_gen_pkg;

    localparam int CNT_W_DEF       = 28;
    localparam int DIV_1HZ_50MHZ   = 50_000_000;
    localparam int DIV_DEFAULT_DEF = DIV_1HZ_50MHZ;

    typedef logic [CNT_W_DEF-1:0] div_t;

endpackage

// File: rtl/tick_stage.sv
// One cascaded mod-STAGE_DIV divider stage; carry_out_o fires on the carry that wraps it.
module tick_stage #(
    parameter int STAGE_DIV = 10
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic en_i,
    input  logic clr_i,
    input  logic carry_in_i,
    output logic carry_out_o
);

    localparam int W = (STAGE_DIV > 1) ? $clog2(STAGE_DIV) : 1;
    localparam logic [W-1:0] LAST = W'(STAGE_DIV - 1);

    logic [W-1:0] cnt_q, cnt_d;
    logic         adv;

    assign adv         = en_i && carry_in_i;
    assign carry_out_o = adv && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i || carry_out_o) begin
            cnt_d = '0;
        end else if (adv) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/tick_gen_multi.sv
// Programmable base prescaler plus NUM_CH-1 cascaded stages producing aligned ticks.
// Optional square-wave outputs are built when TICK_SQUARE_EN is defined.
module tick_gen_multi
    import tick_gen_pkg::*;
#(
    parameter int CNT_W       = CNT_W_DEF,
    parameter int DIV_DEFAULT = DIV_DEFAULT_DEF,
    parameter int NUM_CH      = 3,
    parameter int STAGE_DIV   = 10
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              en_i,
    input  logic              clr_i,
    input  logic              div_load_i,
    input  logic [CNT_W-1:0]  div_val_i,
    output logic [CNT_W-1:0]  div_cur_o,
    output logic              load_pend_o,
    output logic [NUM_CH-1:0] tick_o
`ifdef TICK_SQUARE_EN
    ,
    output logic [NUM_CH-1:0] square_o
`endif
);

    localparam logic [CNT_W-1:0] DIV_RST = CNT_W'(DIV_DEFAULT);

    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  div_cur_q, div_cur_d;
    logic [CNT_W-1:0]  shadow_q, shadow_d;
    logic [CNT_W-1:0]  div_in;
    logic              load_pend_q, load_pend_d;
    logic              wrap, act, swap;
    logic [NUM_CH-1:0] carry;
    logic [NUM_CH-1:0] tick_q, tick_d;

    assign div_in   = (div_val_i == '0) ? CNT_W'(1) : div_val_i;
    assign wrap     = en_i && (cnt_q == div_cur_q - CNT_W'(1));
    // A new divisor may only take effect at a period boundary, on clear, or while idle.
    assign act      = wrap || clr_i || !en_i;
    assign carry[0] = wrap;

    for (genvar k = 1; k < NUM_CH; k++) begin : g_stage
        tick_stage #(
            .STAGE_DIV (STAGE_DIV)
        ) u_stage (
            .clk_i       (clk_i),
            .rst_i       (rst_i),
            .en_i        (en_i),
            .clr_i       (clr_i),
            .carry_in_i  (carry[k-1]),
            .carry_out_o (carry[k])
        );
    end

    always_comb begin
        div_cur_d   = div_cur_q;
        shadow_d    = shadow_q;
        load_pend_d = load_pend_q;
        swap        = 1'b0;
        if (div_load_i) begin
            shadow_d = div_in;
            if (act) begin
                div_cur_d   = div_in;
                load_pend_d = 1'b0;
                swap        = 1'b1;
            end else begin
                load_pend_d = 1'b1;
            end
        end else if (load_pend_q && act) begin
            div_cur_d   = shadow_q;
            load_pend_d = 1'b0;
            swap        = 1'b1;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i || swap || wrap) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    assign tick_d = clr_i ? '0 : carry;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q       <= '0;
            div_cur_q   <= DIV_RST;
            shadow_q    <= DIV_RST;
            load_pend_q <= 1'b0;
            tick_q      <= '0;
        end else begin
            cnt_q       <= cnt_d;
            div_cur_q   <= div_cur_d;
            shadow_q    <= shadow_d;
            load_pend_q <= load_pend_d;
            tick_q      <= tick_d;
        end
    end

    assign div_cur_o   = div_cur_q;
    assign load_pend_o = load_pend_q;
    assign tick_o      = tick_q;

`ifdef TICK_SQUARE_EN
    logic [NUM_CH-1:0] square_q, square_d;

    assign square_d = clr_i ? '0 : (square_q ^ carry);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            square_q <= '0;
        end else begin
            square_q <= square_d;
        end
    end

    assign square_o = square_q;
`endif

endmodule

// File: tb/tb_tick_gen_multi.sv
// Directed bench for tick_gen_multi with DIV_DEFAULT=4, NUM_CH=2, STAGE_DIV=3.
module tb_tick_gen_multi;

    localparam int CNT_W       = 8;
    localparam int DIV_DEFAULT = 4;
    localparam int NUM_CH      = 2;
    localparam int STAGE_DIV   = 3;

    logic              clk = 1'b0;
    logic              rst, en, clr, div_load;
    logic [CNT_W-1:0]  div_val;
    logic [CNT_W-1:0]  div_cur;
    logic              load_pend;
    logic [NUM_CH-1:0] tick;
`ifdef TICK_SQUARE_EN
    logic [NUM_CH-1:0] square;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    tick_gen_multi #(
        .CNT_W       (CNT_W),
        .DIV_DEFAULT (DIV_DEFAULT),
        .NUM_CH      (NUM_CH),
        .STAGE_DIV   (STAGE_DIV)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .en_i        (en),
        .clr_i       (clr),
        .div_load_i  (div_load),
        .div_val_i   (div_val),
        .div_cur_o   (div_cur),
        .load_pend_o (load_pend),
        .tick_o      (tick)
`ifdef TICK_SQUARE_EN
        ,
        .square_o    (square)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; clr = 1'b0; div_load = 1'b0; div_val = '0;
        step();
        step();
        check("rst tick", 32'(tick), 0);
        check("rst div_cur", 32'(div_cur), 4);
        check("rst load_pend", 32'(load_pend), 0);
`ifdef TICK_SQUARE_EN
        check("rst square", 32'(square), 0);
`endif

        // Free-running with the reset divisor.
        rst = 1'b0; en = 1'b1;
        for (int n = 1; n <= 24; n++) begin
            step();
            check($sformatf("t1 tick0 c%0d", n), 32'(tick[0]), 32'(n % 4 == 0));
            check($sformatf("t1 tick1 c%0d", n), 32'(tick[1]), 32'(n % 12 == 0));
`ifdef TICK_SQUARE_EN
            check($sformatf("t1 sq0 c%0d", n), 32'(square[0]), 32'((n / 4) % 2));
            check($sformatf("t1 sq1 c%0d", n), 32'(square[1]), 32'((n / 12) % 2));
`endif
        end

        // Enable gap stretches the period by its length.
        clr = 1'b1;
        step();
        clr = 1'b0;
        check("t2 clr tick", 32'(tick), 0);
        step();
        step();
        en = 1'b0;
        for (int j = 1; j <= 5; j++) begin
            step();
            check($sformatf("t2 off tick0 %0d", j), 32'(tick[0]), 0);
        end
        en = 1'b1;
        step();
        check("t2 pre tick0", 32'(tick[0]), 0);
        step();
        check("t2 late tick0", 32'(tick[0]), 1);

        // Reload at a non-wrap edge, then overwrite and coincident load.
        clr = 1'b1;
        step();
        clr = 1'b0;
        for (int m = 1; m <= 22; m++) begin
            div_load = (m == 6 || m == 15 || m == 16);
            div_val  = (m == 6) ? 8'd2 : (m == 15) ? 8'd7 : (m == 16) ? 8'd3 : 8'd0;
            step();
            div_load = 1'b0;
            check($sformatf("t3 tick0 c%0d", m), 32'(tick[0]),
                  32'(m inside {4, 8, 10, 12, 14, 16, 19, 22}));
            check($sformatf("t3 tick1 c%0d", m), 32'(tick[1]), 32'(m == 10 || m == 16));
            if (m == 6 || m == 7 || m == 15)
                check($sformatf("t3 pend c%0d", m), 32'(load_pend), 1);
            if (m == 8 || m == 16)
                check($sformatf("t3 pend c%0d", m), 32'(load_pend), 0);
            if (m == 7)  check("t3 div_cur c7", 32'(div_cur), 4);
            if (m == 8)  check("t3 div_cur c8", 32'(div_cur), 2);
            if (m == 15) check("t3 div_cur c15", 32'(div_cur), 2);
            if (m == 16) check("t3 div_cur c16", 32'(div_cur), 3);
        end

        // Zero divisor loaded while idle becomes 1 immediately.
        en = 1'b0; div_load = 1'b1; div_val = '0;
        step();
        div_load = 1'b0;
        check("t4 div_cur", 32'(div_cur), 1);
        check("t4 pend", 32'(load_pend), 0);
        check("t4 tick", 32'(tick), 0);
        clr = 1'b1;
        step();
        clr = 1'b0; en = 1'b1;
        for (int j = 1; j <= 6; j++) begin
            step();
            check($sformatf("t4 tick0 %0d", j), 32'(tick[0]), 1);
            check($sformatf("t4 tick1 %0d", j), 32'(tick[1]), 32'(j % 3 == 0));
        end

        // Clear just before a wrap suppresses the tick and restarts the period.
        en = 1'b0; div_load = 1'b1; div_val = 8'd4;
        step();
        div_load = 1'b0;
        check("t5 div_cur", 32'(div_cur), 4);
        en = 1'b1; clr = 1'b1;
        step();
        clr = 1'b0;
        for (int j = 1; j <= 3; j++) begin
            step();
            check($sformatf("t5 tick0 %0d", j), 32'(tick[0]), 0);
        end
        clr = 1'b1;
        step();
        clr = 1'b0;
        check("t5 clr tick0", 32'(tick[0]), 0);
`ifdef TICK_SQUARE_EN
        check("t5 clr sq0", 32'(square[0]), 0);
`endif
        for (int j = 5; j <= 8; j++) begin
            step();
            check($sformatf("t5 tick0 %0d", j), 32'(tick[0]), 32'(j == 8));
        end
`ifdef TICK_SQUARE_EN
        check("t5 sq0 after tick", 32'(square[0]), 1);
`endif

        // Reset discards a pending load.
        div_load = 1'b1; div_val = 8'd9;
        step();
        div_load = 1'b0;
        check("t6 pend", 32'(load_pend), 1);
        check("t6 div_cur held", 32'(div_cur), 4);
        rst = 1'b1;
        step();
        check("t6 rst div_cur", 32'(div_cur), 4);
        check("t6 rst pend", 32'(load_pend), 0);
        check("t6 rst tick", 32'(tick), 0);
        rst = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
